// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the multicycle-CPU memory controller.
// Imported by rv_mem_ctl and its wait-state counter.
package rv_mem_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} mem_st_t;

   typedef enum logic {OP_RD, OP_WR} mem_op_t;

   localparam int WAITW = 4;

endpackage

// File: rtl/rv_wait_cnt.sv
// Loadable down-counter that times the SRAM wait states.
// It counts down to zero and then holds there.
module rv_wait_cnt
   import rv_mem_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WAITW-1:0] load_val,
   output logic             zero
);

   logic [WAITW-1:0] cnt;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/rv_mem_ctl.sv
// Memory controller between the multicycle control FSM and a word-addressed synchronous SRAM.
// Adds programmable wait states and rejects misaligned or out-of-range accesses.
module rv_mem_ctl
   import rv_mem_pkg::*;
#(
   parameter int          AW          = 10,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_rd,
   input  logic          req_wr,
   input  logic [31:0]   addr,
   input  logic [31:0]   wdata,
   output logic          ready,
   output logic          done,
   output logic [31:0]   rdata,
   output logic          err,
   output logic          sram_en,
   output logic          sram_we,
   output logic [AW-1:0] sram_addr,
   output logic [31:0]   sram_wdata,
   input  logic [31:0]   sram_rdata
);

   mem_st_t     state, state_nx;
   mem_op_t     op_q, op_nx;
   logic [31:0] word;
   logic        bad;
   logic        accept;
   logic        go_access;
   logic        cnt_zero;

   // The addr < BASE_ADDR term catches underflow, so the wrapped offset is never used.
   assign word      = (addr - BASE_ADDR) >> 2;
   assign bad       = (addr[1:0] != 2'b00) || (addr < BASE_ADDR) || ((word >> AW) != 32'h0);
   assign ready     = (state == IDLE);
   assign accept    = ready && (req_rd || req_wr);
   assign go_access = accept && !bad;
   assign op_nx     = req_wr ? OP_WR : OP_RD;

   rv_wait_cnt u_wait_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (go_access),
      .en       ((state == ACCESS) || (state == WAIT)),
      .load_val (WAITW'(WAIT_CYCLES)),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = bad ? DONE : ACCESS;
         ACCESS:  state_nx = (WAIT_CYCLES == 0) ? DONE : WAIT;
         WAIT:    if (cnt_zero) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are registered from the next state so the SRAM sees glitch-free strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q       <= OP_RD;
         done       <= 1'b0;
         err        <= 1'b0;
         rdata      <= '0;
         sram_en    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
      end else begin
         sram_en <= go_access;
         sram_we <= go_access && req_wr;
         done    <= (state_nx == DONE);
         err     <= accept && bad;
         if (go_access) begin
            op_q       <= op_nx;
            sram_addr  <= word[AW-1:0];
            sram_wdata <= wdata;
         end
         if (accept && bad && !req_wr) begin
            rdata <= '0;
         end else if ((state_nx == DONE) && (state != IDLE) && (op_q == OP_RD)) begin
            rdata <= sram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_rv_mem_ctl.sv
// Directed bench for rv_mem_ctl: one instance with 2 wait states at base 0, one with none at base 0x100.
// Each instance drives its own behavioural SRAM that honours the WAIT_CYCLES read latency.
module tb_rv_mem_ctl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Instance A: AW=10, WAIT_CYCLES=2, BASE_ADDR=0
   logic        req_rd_a = 0, req_wr_a = 0;
   logic [31:0] addr_a = 0, wdata_a = 0;
   logic        ready_a, done_a, err_a, sram_en_a, sram_we_a;
   logic [31:0] rdata_a, sram_wdata_a, sram_rdata_a;
   logic [9:0]  sram_addr_a;

   // Instance B: AW=10, WAIT_CYCLES=0, BASE_ADDR=0x100
   logic        req_rd_b = 0, req_wr_b = 0;
   logic [31:0] addr_b = 0, wdata_b = 0;
   logic        ready_b, done_b, err_b, sram_en_b, sram_we_b;
   logic [31:0] rdata_b, sram_wdata_b, sram_rdata_b;
   logic [9:0]  sram_addr_b;

   rv_mem_ctl #(.AW(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut_a (
      .clk(clk), .rst(rst), .req_rd(req_rd_a), .req_wr(req_wr_a), .addr(addr_a), .wdata(wdata_a),
      .ready(ready_a), .done(done_a), .rdata(rdata_a), .err(err_a),
      .sram_en(sram_en_a), .sram_we(sram_we_a), .sram_addr(sram_addr_a),
      .sram_wdata(sram_wdata_a), .sram_rdata(sram_rdata_a)
   );

   rv_mem_ctl #(.AW(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h100)) dut_b (
      .clk(clk), .rst(rst), .req_rd(req_rd_b), .req_wr(req_wr_b), .addr(addr_b), .wdata(wdata_b),
      .ready(ready_b), .done(done_b), .rdata(rdata_b), .err(err_b),
      .sram_en(sram_en_b), .sram_we(sram_we_b), .sram_addr(sram_addr_b),
      .sram_wdata(sram_wdata_b), .sram_rdata(sram_rdata_b)
   );

   // SRAM A: data for an en cycle appears two cycles later
   logic [31:0] mem_a [0:1023];
   logic [31:0] pipe_a0 = 32'hBAD0BAD0, pipe_a1 = 32'hBAD0BAD0;
   always @(posedge clk) begin
      pipe_a0 <= (sram_en_a && !sram_we_a) ? mem_a[sram_addr_a] : 32'hBAD0BAD0;
      pipe_a1 <= pipe_a0;
      if (sram_en_a && sram_we_a) mem_a[sram_addr_a] = sram_wdata_a;
   end
   assign sram_rdata_a = pipe_a1;

   // SRAM B: zero wait states, data visible during the en cycle itself
   logic [31:0] mem_b [0:1023];
   always @(posedge clk) begin
      if (sram_en_b && sram_we_b) mem_b[sram_addr_b] = sram_wdata_b;
   end
   assign sram_rdata_b = (sram_en_b && !sram_we_b) ? mem_b[sram_addr_b] : 32'hBAD0BAD0;

   int en_cnt_a = 0, done_cnt_a = 0;
   always @(posedge clk) begin
      if (sram_en_a) en_cnt_a++;
      if (done_a)    done_cnt_a++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Holds the request until done (or a 40-cycle bound) and records done cycle and strobe counts.
   task automatic run_a(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int dcyc, output int en_n, output int we_n, output logic err_s);
      req_rd_a = rd; req_wr_a = wr; addr_a = a; wdata_a = d;
      dcyc = -1; en_n = 0; we_n = 0; err_s = 1'bx;
      for (int c = 1; c <= 40; c++) begin
         tick;
         if (sram_en_a) en_n++;
         if (sram_we_a) we_n++;
         if (done_a) begin dcyc = c; err_s = err_a; break; end
      end
      req_rd_a = 0; req_wr_a = 0;
   endtask

   task automatic run_b(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int dcyc, output int en_n, output int we_n, output logic err_s);
      req_rd_b = rd; req_wr_b = wr; addr_b = a; wdata_b = d;
      dcyc = -1; en_n = 0; we_n = 0; err_s = 1'bx;
      for (int c = 1; c <= 40; c++) begin
         tick;
         if (sram_en_b) en_n++;
         if (sram_we_b) we_n++;
         if (done_b) begin dcyc = c; err_s = err_b; break; end
      end
      req_rd_b = 0; req_wr_b = 0;
   endtask

   task automatic test_reset;
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (ready_a !== 1'b1)       begin n_bad++; $display("FAIL rst_ready: got %b want 1", ready_a); end
      n_cmp++; if (done_a !== 1'b0)        begin n_bad++; $display("FAIL rst_done: got %b want 0", done_a); end
      n_cmp++; if (err_a !== 1'b0)         begin n_bad++; $display("FAIL rst_err: got %b want 0", err_a); end
      n_cmp++; if (rdata_a !== 32'h0)      begin n_bad++; $display("FAIL rst_rdata: got %h want 0", rdata_a); end
      n_cmp++; if ({sram_en_a, sram_we_a} !== 2'b00) begin n_bad++; $display("FAIL rst_en_we: got %b want 00", {sram_en_a, sram_we_a}); end
      n_cmp++; if (sram_addr_a !== 10'h0)  begin n_bad++; $display("FAIL rst_sram_addr: got %h want 0", sram_addr_a); end
      n_cmp++; if (sram_wdata_a !== 32'h0) begin n_bad++; $display("FAIL rst_sram_wdata: got %h want 0", sram_wdata_a); end
      @(negedge clk) rst = 1'b1;
      tick;
   endtask

   task automatic test_read;
      int e0;
      e0 = en_cnt_a;
      req_rd_a = 1; addr_a = 32'h14;
      n_cmp++; if (ready_a !== 1'b1) begin n_bad++; $display("FAIL rd_ready_c0: got %b want 1", ready_a); end
      tick;
      n_cmp++; if ({sram_en_a, sram_we_a} !== 2'b10) begin n_bad++; $display("FAIL rd_en_c1: got %b want 10", {sram_en_a, sram_we_a}); end
      n_cmp++; if (sram_addr_a !== 10'd5) begin n_bad++; $display("FAIL rd_addr_c1: got %0d want 5", sram_addr_a); end
      n_cmp++; if (ready_a !== 1'b0) begin n_bad++; $display("FAIL rd_ready_c1: got %b want 0", ready_a); end
      tick;
      n_cmp++; if ({sram_en_a, done_a} !== 2'b00) begin n_bad++; $display("FAIL rd_c2: got en,done=%b want 00", {sram_en_a, done_a}); end
      tick;
      n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL rd_done_c3: got %b want 0", done_a); end
      tick;
      n_cmp++; if ({done_a, err_a} !== 2'b10) begin n_bad++; $display("FAIL rd_done_c4: got done,err=%b want 10", {done_a, err_a}); end
      n_cmp++; if (rdata_a !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_rdata_c4: got %h want deadbeef", rdata_a); end
      req_rd_a = 0;
      tick;
      n_cmp++; if ({ready_a, done_a} !== 2'b10) begin n_bad++; $display("FAIL rd_c5: got ready,done=%b want 10", {ready_a, done_a}); end
      n_cmp++; if (rdata_a !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_hold: got %h want deadbeef", rdata_a); end
      n_cmp++; if (en_cnt_a - e0 !== 1) begin n_bad++; $display("FAIL rd_en_pulses: got %0d want 1", en_cnt_a - e0); end
   endtask

   task automatic test_write;
      int dc, en, we; logic es;
      // W=2: the write strobe is a single cycle and rdata keeps the last read value
      run_a(0, 1, 32'h8, 32'h1234, dc, en, we, es);
      n_cmp++; if (dc !== 4) begin n_bad++; $display("FAIL wr_a_done_cycle: got %0d want 4", dc); end
      n_cmp++; if ({en, we} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL wr_a_strobes: got en=%0d we=%0d want 1,1", en, we); end
      n_cmp++; if (rdata_a !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_a_rdata_kept: got %h want deadbeef", rdata_a); end
      tick;
      run_a(1, 0, 32'h8, 32'h0, dc, en, we, es);
      n_cmp++; if (rdata_a !== 32'h1234) begin n_bad++; $display("FAIL wr_a_readback: got %h want 1234", rdata_a); end
      tick;
      // W=0, BASE=0x100: byte 0x108 is word 2
      run_b(0, 1, 32'h108, 32'h1234, dc, en, we, es);
      n_cmp++; if (dc !== 2) begin n_bad++; $display("FAIL wr_b_done_cycle: got %0d want 2", dc); end
      n_cmp++; if ({en, we} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL wr_b_strobes: got en=%0d we=%0d want 1,1", en, we); end
      n_cmp++; if ({sram_addr_b, sram_wdata_b} !== {10'd2, 32'h1234}) begin n_bad++; $display("FAIL wr_b_addr_data: got %0d/%h want 2/1234", sram_addr_b, sram_wdata_b); end
      tick;
      run_b(1, 0, 32'h108, 32'h0, dc, en, we, es);
      n_cmp++; if (dc !== 2) begin n_bad++; $display("FAIL rd_b_done_cycle: got %0d want 2", dc); end
      n_cmp++; if (rdata_b !== 32'h1234) begin n_bad++; $display("FAIL rd_b_readback: got %h want 1234", rdata_b); end
      tick;
   endtask

   task automatic test_misaligned;
      int dc, en, we; logic es;
      run_a(1, 0, 32'h6, 32'h0, dc, en, we, es);
      n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL mis_done_cycle: got %0d want 1", dc); end
      n_cmp++; if (es !== 1'b1) begin n_bad++; $display("FAIL mis_err: got %b want 1", es); end
      n_cmp++; if (rdata_a !== 32'h0) begin n_bad++; $display("FAIL mis_rdata: got %h want 0", rdata_a); end
      tick;
      n_cmp++; if ({en, sram_en_a, ready_a, err_a} !== {32'd0, 1'b0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL mis_after: got en=%0d sram_en=%b ready=%b err=%b want 0,0,1,0", en, sram_en_a, ready_a, err_a); end
   endtask

   task automatic test_range;
      int dc, en, we; logic es;
      run_a(1, 0, 32'h1000, 32'h0, dc, en, we, es);
      n_cmp++; if ({dc, en, es} !== {32'd1, 32'd0, 1'b1}) begin n_bad++; $display("FAIL rng_a_1000: got cyc=%0d en=%0d err=%b want 1,0,1", dc, en, es); end
      tick;
      run_b(1, 0, 32'hFC, 32'h0, dc, en, we, es);
      n_cmp++; if ({dc, en, es} !== {32'd1, 32'd0, 1'b1}) begin n_bad++; $display("FAIL rng_b_below_base: got cyc=%0d en=%0d err=%b want 1,0,1", dc, en, es); end
      tick;
      run_b(0, 1, 32'h1100, 32'h55, dc, en, we, es);
      n_cmp++; if ({dc, en, we, es} !== {32'd1, 32'd0, 32'd0, 1'b1}) begin n_bad++; $display("FAIL rng_b_word1024: got cyc=%0d en=%0d we=%0d err=%b want 1,0,0,1", dc, en, we, es); end
      tick;
      run_b(0, 1, 32'h10FC, 32'hA5A5A5A5, dc, en, we, es);
      n_cmp++; if ({dc, es, sram_addr_b} !== {32'd2, 1'b0, 10'd1023}) begin n_bad++; $display("FAIL rng_b_word1023: got cyc=%0d err=%b addr=%0d want 2,0,1023", dc, es, sram_addr_b); end
      tick;
   endtask

   task automatic test_simultaneous;
      int dc, en, we, e0; logic es;
      run_a(1, 1, 32'h20, 32'hCAFEF00D, dc, en, we, es);
      n_cmp++; if ({dc, we, es} !== {32'd4, 32'd1, 1'b0}) begin n_bad++; $display("FAIL sim_write_wins: got cyc=%0d we=%0d err=%b want 4,1,0", dc, we, es); end
      tick;
      run_a(1, 0, 32'h20, 32'h0, dc, en, we, es);
      n_cmp++; if (rdata_a !== 32'hCAFEF00D) begin n_bad++; $display("FAIL sim_readback: got %h want cafef00d", rdata_a); end
      tick;
      // A second request raised in cycle 2 of a read must be ignored
      e0 = en_cnt_a;
      req_rd_a = 1; addr_a = 32'h14;
      tick; tick;
      req_wr_a = 1; addr_a = 32'h30; wdata_a = 32'h77;
      tick; tick;
      n_cmp++; if ({done_a, rdata_a} !== {1'b1, 32'hDEADBEEF}) begin n_bad++; $display("FAIL busy_done: got done=%b rdata=%h want 1/deadbeef", done_a, rdata_a); end
      req_rd_a = 0; req_wr_a = 0;
      tick;
      n_cmp++; if ({en_cnt_a - e0, sram_we_a, ready_a} !== {32'd1, 1'b0, 1'b1}) begin n_bad++; $display("FAIL busy_ignored: got en=%0d we=%b ready=%b want 1,0,1", en_cnt_a - e0, sram_we_a, ready_a); end
   endtask

   task automatic test_back_to_back;
      int dc, en, we; logic es;
      run_b(1, 0, 32'h108, 32'h0, dc, en, we, es);
      // Called from the DONE cycle: accepted one cycle later in IDLE, done two cycles after that
      run_b(1, 0, 32'h108, 32'h0, dc, en, we, es);
      n_cmp++; if ({dc, en} !== {32'd3, 32'd1}) begin n_bad++; $display("FAIL b2b_cycle: got cyc=%0d en=%0d want 3,1", dc, en); end
      n_cmp++; if (rdata_b !== 32'h1234) begin n_bad++; $display("FAIL b2b_rdata: got %h want 1234", rdata_b); end
      tick;
   endtask

   task automatic test_reset_mid;
      int dc, en, we, d0; logic es;
      d0 = done_cnt_a;
      req_rd_a = 1; addr_a = 32'h14;
      tick; tick;
      #2 rst = 1'b0;
      #1;
      n_cmp++; if ({sram_en_a, sram_we_a, done_a, err_a, ready_a} !== 5'b00001) begin n_bad++; $display("FAIL rstmid_outs: got en,we,done,err,ready=%b want 00001", {sram_en_a, sram_we_a, done_a, err_a, ready_a}); end
      n_cmp++; if ({rdata_a, sram_addr_a} !== {32'h0, 10'h0}) begin n_bad++; $display("FAIL rstmid_data: got rdata=%h addr=%h want 0/0", rdata_a, sram_addr_a); end
      req_rd_a = 0;
      @(negedge clk) rst = 1'b1;
      tick; tick; tick; tick;
      n_cmp++; if (done_cnt_a !== d0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt_a - d0); end
      run_a(1, 0, 32'h14, 32'h0, dc, en, we, es);
      n_cmp++; if ({dc, rdata_a} !== {32'd4, 32'hDEADBEEF}) begin n_bad++; $display("FAIL rstmid_recover: got cyc=%0d rdata=%h want 4/deadbeef", dc, rdata_a); end
      tick;
   endtask

   initial begin
      mem_a[5] = 32'hDEADBEEF;
      test_reset;
      test_read;
      test_write;
      test_misaligned;
      test_range;
      test_simultaneous;
      test_back_to_back;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
